// File: rtl/matvec_ctrl.sv
// Control FSM for the KxK matrix-vector multiplier: loads matrix/vector memories,
// sequences the per-row multiply-accumulate and runs the output handshake.
module matvec_ctrl #(
    parameter  int K  = 8,
    localparam int MW = (K * K > 1) ? $clog2(K * K) : 1,
    localparam int XW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          input_valid,
    output logic          input_ready,
    input  logic          new_matrix,
    output logic          output_valid,
    input  logic          output_ready,
    output logic [MW-1:0] addr_m,
    output logic          wr_en_m,
    output logic [XW-1:0] addr_x,
    output logic          wr_en_x,
    output logic          en_acc,
    output logic          clear_acc
);

    typedef enum logic [2:0] {
        START  = 3'd0,
        LOAD_M = 3'd1,
        LOAD_X = 3'd2,
        MAC    = 3'd3,
        DRAIN  = 3'd4,
        OUT    = 3'd5
    } state_t;

    localparam logic [MW-1:0] N_LAST = MW'(K * K - 1);
    localparam logic [XW-1:0] K_LAST = XW'(K - 1);
    localparam logic [MW-1:0] K_ROW  = MW'(K);

    state_t        state, state_nxt;
    logic [MW-1:0] n, n_nxt;
    logic [XW-1:0] k, k_nxt;
    logic [XW-1:0] r, r_nxt;
    logic [XW-1:0] c, c_nxt;

    logic          can_load;
    logic          accept;
    logic          wr_m, wr_x, ov;
    logic [MW-1:0] am;
    logic [XW-1:0] ax;
    logic          issue_p0, first_p0;
    logic          vld_p1, clr_p1;

    // input_ready is a pure function of state (and reset), never of input_valid
    assign can_load    = (state == START) || (state == LOAD_M) || (state == LOAD_X);
    assign input_ready = can_load && !reset;
    assign accept      = input_valid && input_ready;

    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        k_nxt     = k;
        r_nxt     = r;
        c_nxt     = c;
        wr_m      = 1'b0;
        wr_x      = 1'b0;
        ov        = 1'b0;
        am        = '0;
        ax        = '0;
        issue_p0  = 1'b0;
        first_p0  = 1'b0;
        case (state)
            START: begin
                if (accept) begin
                    if (new_matrix) begin
                        wr_m      = 1'b1;
                        n_nxt     = MW'(1);
                        state_nxt = LOAD_M;
                    end else begin
                        wr_x      = 1'b1;
                        k_nxt     = XW'(1);
                        state_nxt = LOAD_X;
                    end
                end
            end
            LOAD_M: begin
                am = n;
                if (accept) begin
                    wr_m = 1'b1;
                    if (n == N_LAST) begin
                        k_nxt     = '0;
                        state_nxt = LOAD_X;
                    end else begin
                        n_nxt = n + MW'(1);
                    end
                end
            end
            LOAD_X: begin
                ax = k;
                if (accept) begin
                    wr_x = 1'b1;
                    if (k == K_LAST) begin
                        r_nxt     = '0;
                        c_nxt     = '0;
                        state_nxt = MAC;
                    end else begin
                        k_nxt = k + XW'(1);
                    end
                end
            end
            MAC: begin
                am       = MW'(r) * K_ROW + MW'(c);
                ax       = c;
                issue_p0 = 1'b1;
                first_p0 = (c == '0);
                if (c == K_LAST) begin
                    state_nxt = DRAIN;
                end else begin
                    c_nxt = c + XW'(1);
                end
            end
            DRAIN: begin
                am        = MW'(r) * K_ROW + MW'(c);
                ax        = c;
                state_nxt = OUT;
            end
            OUT: begin
                am = MW'(r) * K_ROW + MW'(c);
                ax = c;
                ov = 1'b1;
                if (output_ready) begin
                    if (r == K_LAST) begin
                        state_nxt = START;
                    end else begin
                        r_nxt     = r + XW'(1);
                        c_nxt     = '0;
                        state_nxt = MAC;
                    end
                end
            end
            default: state_nxt = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= START;
            n     <= '0;
            k     <= '0;
            r     <= '0;
            c     <= '0;
        end else begin
            state <= state_nxt;
            n     <= n_nxt;
            k     <= k_nxt;
            r     <= r_nxt;
            c     <= c_nxt;
        end
    end

    // p0 -> p1: accumulate controls trail the address issue by the memory read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            clr_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue_p0;
            clr_p1 <= issue_p0 && first_p0;
        end
    end

    assign wr_en_m      = wr_m && !reset;
    assign wr_en_x      = wr_x && !reset;
    assign output_valid = ov && !reset;
    assign addr_m       = reset ? '0 : am;
    assign addr_x       = reset ? '0 : ax;
    assign en_acc       = vld_p1 && !reset;
    assign clear_acc    = clr_p1 && !reset;

endmodule

// File: tb/tb_matvec_ctrl.sv
// Directed bench for matvec_ctrl: a scoreboard queue holds the expected write,
// accumulate and output events in order; a negedge monitor pops and compares them.
module tb_matvec_ctrl;

    localparam int K  = 8;
    localparam int MW = $clog2(K * K);
    localparam int XW = $clog2(K);

    localparam logic [2:0] EV_M = 3'd1;
    localparam logic [2:0] EV_X = 3'd2;
    localparam logic [2:0] EV_A = 3'd3;
    localparam logic [2:0] EV_O = 3'd4;

    typedef logic [14:0] rec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          input_valid;
    logic          input_ready;
    logic          new_matrix;
    logic          output_valid;
    logic          output_ready;
    logic [MW-1:0] addr_m;
    logic          wr_en_m;
    logic [XW-1:0] addr_x;
    logic          wr_en_x;
    logic          en_acc;
    logic          clear_acc;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    rec_t q[$];

    matvec_ctrl #(.K(K)) dut (
        .clk         (clk),
        .reset       (reset),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .new_matrix  (new_matrix),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .addr_m      (addr_m),
        .wr_en_m     (wr_en_m),
        .addr_x      (addr_x),
        .wr_en_x     (wr_en_x),
        .en_acc      (en_acc),
        .clear_acc   (clear_acc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic rec_t mk(input logic [2:0] kd, input int a, input int x, input logic cl);
        return {kd, 6'(a), 5'(x), cl};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input rec_t obs);
        rec_t exp;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed event %0h expected none (queue empty)", tag, obs);
        end else begin
            exp = q.pop_front();
            chk(tag, 32'(obs), 32'(exp));
        end
    endtask

    task automatic push_load(input bit with_m);
        if (with_m)
            for (int i = 0; i < K * K; i++) q.push_back(mk(EV_M, i, 0, 1'b0));
        for (int i = 0; i < K; i++) q.push_back(mk(EV_X, 0, i, 1'b0));
    endtask

    task automatic push_row(input int r, input bit with_out);
        for (int c = 0; c < K; c++) q.push_back(mk(EV_A, r * K + c, c, c == 0));
        if (with_out) q.push_back(mk(EV_O, 0, K, 1'b0));
    endtask

    // One word; waits (bounded) for input_ready, returns the cycle number of acceptance
    task automatic send(input logic nm, input int gap, output int tacc);
        int g;
        input_valid = 1'b0;
        new_matrix  = 1'bx;
        repeat (gap) begin @(posedge clk); #1; end
        input_valid = 1'b1;
        new_matrix  = nm;
        g = 0;
        while (!input_ready && g < 200) begin @(posedge clk); #1; g++; end
        if (g >= 200) chk("send_timeout", 32'(g), 32'(0));
        tacc = cyc;
        @(posedge clk); #1;
        input_valid = 1'b0;
        new_matrix  = 1'bx;
    endtask

    task automatic wait_ov();
        int g = 0;
        while (!output_valid && g < 50) begin @(posedge clk); #1; g++; end
        if (g >= 50) chk("ov_timeout", 32'(g), 32'(0));
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!input_ready && g < 300) begin @(posedge clk); #1; g++; end
        if (g >= 300) chk("ready_timeout", 32'(g), 32'(0));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(input_ready), 32'(1));
        chk({tag, "_outs"},
            32'({output_valid, wr_en_m, wr_en_x, en_acc, clear_acc, addr_m, addr_x}), 32'(0));
    endtask

    logic [MW-1:0] pam;
    logic [XW-1:0] pax;
    int            acnt = 0;

    // Monitor: writes, accumulates (checked against last cycle's issue) and handshakes
    always @(negedge clk) begin
        if (reset) begin
            acnt = 0;
        end else begin
            if (wr_en_m) sb_pop("wr_m", mk(EV_M, int'(addr_m), 0, 1'b0));
            if (wr_en_x) sb_pop("wr_x", mk(EV_X, 0, int'(addr_x), 1'b0));
            if (en_acc) begin
                sb_pop("acc", mk(EV_A, int'(pam), int'(pax), clear_acc));
                acnt++;
            end
            if (clear_acc && !en_acc) chk("clear_without_en", 32'(en_acc), 32'(1));
            if (output_valid) chk("out_holds_acc", 32'(en_acc), 32'(0));
            if (output_valid && output_ready) begin
                sb_pop("out", mk(EV_O, 0, acnt, 1'b0));
                acnt = 0;
            end
        end
        pam = addr_m;
        pax = addr_x;
    end

    initial begin
        int t0, tx;
        reset        = 1'b1;
        input_valid  = 1'b0;
        new_matrix   = 1'b0;
        output_ready = 1'b1;

        @(posedge clk); #1;
        chk("rst_ready", 32'(input_ready), 32'(0));
        chk("rst_outs",
            32'({output_valid, wr_en_m, wr_en_x, en_acc, clear_acc, addr_m, addr_x}), 32'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        chk_idle("post_rst");

        // Product 1: new matrix, back-to-back, new_matrix held 1 on every word
        push_load(1'b1);
        for (int r = 0; r < K; r++) push_row(r, 1'b1);
        send(1'b1, 0, t0);
        for (int i = 1; i < K * K + K; i++) send(1'b1, 0, tx);
        chk("p1_mac_not_ready", 32'(input_ready), 32'(0));
        wait_ov();
        chk("p1_first_ov_cycle", 32'(cyc - t0), 32'(K * K + K + K + 1));
        wait_ready();
        chk("p1_length", 32'(cyc - t0), 32'(152));

        // Product 2: reuse matrix, only K words taken
        push_load(1'b0);
        for (int r = 0; r < K; r++) push_row(r, 1'b1);
        send(1'b0, 0, t0);
        for (int i = 1; i < K; i++) send(1'b1, 0, tx);
        chk("p2_ready_drop", 32'(input_ready), 32'(0));
        wait_ready();
        chk("p2_length", 32'(cyc - t0), 32'(88));
        chk("p2_drained", 32'(q.size()), 32'(0));

        // Product 3: random gaps, each result stalled 5 cycles
        output_ready = 1'b0;
        push_load(1'b1);
        for (int r = 0; r < K; r++) push_row(r, 1'b1);
        send(1'b1, $urandom_range(0, 3), tx);
        for (int i = 1; i < K * K + K; i++) send(1'($urandom_range(0, 1)), $urandom_range(0, 3), tx);
        for (int r = 0; r < K; r++) begin
            wait_ov();
            for (int s = 0; s < 5; s++) begin
                chk("stall_ov", 32'(output_valid), 32'(1));
                @(posedge clk); #1;
            end
            output_ready = 1'b1;
            @(posedge clk); #1;
            output_ready = 1'b0;
            chk("ov_after_hs", 32'(output_valid), 32'(0));
        end
        wait_ready();
        chk("p3_drained", 32'(q.size()), 32'(0));

        // Reset in LOAD_M with n=30, a word offered during the reset cycle
        for (int i = 0; i < 30; i++) q.push_back(mk(EV_M, i, 0, 1'b0));
        send(1'b1, 0, tx);
        for (int i = 1; i < 30; i++) send(1'b1, 0, tx);
        input_valid = 1'b1;
        new_matrix  = 1'b1;
        reset       = 1'b1;
        #1;
        chk("rst_m_ready", 32'(input_ready), 32'(0));
        chk("rst_m_wr", 32'({wr_en_m, wr_en_x}), 32'(0));
        @(posedge clk); #1;
        reset       = 1'b0;
        input_valid = 1'b0;
        #1;
        chk_idle("rst_m");
        chk("rst_m_queue", 32'(q.size()), 32'(0));

        // Reset while presenting row 4
        push_load(1'b1);
        for (int r = 0; r < 4; r++) push_row(r, 1'b1);
        push_row(4, 1'b0);
        send(1'b1, 0, tx);
        for (int i = 1; i < K * K + K; i++) send(1'b0, 0, tx);
        for (int r = 0; r < 4; r++) begin
            wait_ov();
            output_ready = 1'b1;
            @(posedge clk); #1;
            output_ready = 1'b0;
        end
        wait_ov();
        chk("rst_o_ov_before", 32'(output_valid), 32'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk_idle("rst_o");
        chk("rst_o_queue", 32'(q.size()), 32'(0));

        // Product after reset, reusing stored matrix
        output_ready = 1'b1;
        push_load(1'b0);
        for (int r = 0; r < K; r++) push_row(r, 1'b1);
        send(1'b0, 0, t0);
        for (int i = 1; i < K; i++) send(1'bx, 0, tx);
        wait_ready();
        chk("p4_length", 32'(cyc - t0), 32'(88));
        chk("p4_drained", 32'(q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
